uart_dbg_master: RTL and testbench

UART_DBG_MASTER -- requirements
Module: uart_dbg_master

---
 rtl/uart_dbg_pkg.sv | 28 ++
 rtl/uart_dbg_rx.sv | 95 +++++++++
 rtl/uart_dbg_master.sv | 187 ++++++++++++++++++
 tb/tb_uart_dbg_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared types and byte codes for the UART debug bus master.
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_CYC,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] CMD_READ      = 8'h52;  // 'R'
  localparam logic [7:0] CMD_WRITE     = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ_INC  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_WRITE_INC = 8'h77;  // 'w'
  localparam logic [7:0] RSP_OK        = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR       = 8'h3F;  // '?'

endpackage

// File: rtl/uart_dbg_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, start glitch reject and stop check.
module uart_dbg_rx
  import uart_dbg_pkg::*;
#(
  parameter int BIT_CYC = 2500
) (
  input  logic       clk_in,
  input  logic       b_reset,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(BIT_CYC + 1);
  localparam int HALF  = BIT_CYC / 2;

  // [0],[1] synchronize; [2] is the previous synchronized value for edge detect
  logic [2:0]       sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (sync_q[2] && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_dbg_master.sv
// UART-driven debug bus master: R/W commands hold the CPU and run one bus access.
// Define UART_DBG_AUTOINC_EN for address auto-increment and the 'r'/'w' commands.
module uart_dbg_master
  import uart_dbg_pkg::*;
#(
  parameter int OSC_CLOCK = 12000000,
  parameter int UART_BAUD = 4800,
  parameter int BUS_CYC   = 12,
  parameter int TIMEOUT   = 250000
) (
  input  logic        clk_in,
  input  logic        b_reset,
  input  logic        rxd,
  output logic        txd,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  output logic        rw,
  output logic        vma,
  output logic        err_frame,
  output logic        err_ovr
);

  localparam int BIT_CYC = OSC_CLOCK / UART_BAUD;
  localparam int PH_LAST = BUS_CYC + 1;  // hold phase after vma falls
  localparam int CNT_MAX = (TIMEOUT > PH_LAST) ? TIMEOUT : PH_LAST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TX_W    = $clog2(BIT_CYC + 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_dbg_rx #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk_in     (clk_in),
    .b_reset    (b_reset),
    .rxd_i      (rxd),
    .data_o     (rx_data),
    .valid_o    (rx_valid),
    .frame_err_o(rx_ferr)
  );

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       dout_q, dout_d, rdata_q, rdata_d;
  logic             rd_q, rd_d, frame_q, frame_d, ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_start, tx_done;
  logic [7:0]       tx_byte;

  // Frame shifts out LSB first; idle and refill value is 1 so txd rests high.
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [TX_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bits_q, tx_bits_d;
  logic             tx_busy_q, tx_busy_d;

  assign tx_done = tx_busy_q && (tx_cnt_q == TX_W'(BIT_CYC - 1)) && (tx_bits_q == 4'd9);

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_busy_d  = tx_busy_q;
    if (tx_start) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_cnt_d   = '0;
      tx_bits_d  = '0;
      tx_busy_d  = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == TX_W'(BIT_CYC - 1)) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q + 4'd1;
        if (tx_done) tx_busy_d = 1'b0;
      end else begin
        tx_cnt_d = tx_cnt_q + TX_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    cnt_d    = '0;
    tx_start = 1'b0;
    tx_byte  = RSP_ERR;
    frame_d  = frame_q | rx_ferr;
    ovr_d    = ovr_q | (rx_valid && (state_q == ST_BUS_REQ || state_q == ST_BUS_CYC ||
                                     state_q == ST_RESP));
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_READ:  begin rd_d = 1'b1; state_d = ST_ADDR_H; end
            CMD_WRITE: begin rd_d = 1'b0; state_d = ST_ADDR_H; end
`ifdef UART_DBG_AUTOINC_EN
            CMD_READ_INC:  begin rd_d = 1'b1; state_d = ST_BUS_REQ; end
            CMD_WRITE_INC: begin rd_d = 1'b0; state_d = ST_DATA; end
`endif
            default: begin state_d = ST_RESP; tx_start = 1'b1; tx_byte = RSP_ERR; end
          endcase
        end
      end
      ST_ADDR_H, ST_ADDR_L, ST_DATA: begin
        if (rx_valid) begin
          case (state_q)
            ST_ADDR_H: begin addr_d[15:8] = rx_data; state_d = ST_ADDR_L; end
            ST_ADDR_L: begin addr_d[7:0] = rx_data; state_d = rd_q ? ST_BUS_REQ : ST_DATA; end
            default:   begin dout_d = rx_data; state_d = ST_BUS_REQ; end
          endcase
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BUS_REQ: begin
        if (bus_ack) state_d = ST_BUS_CYC;
      end
      ST_BUS_CYC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rd_q && cnt_q == CNT_W'(BUS_CYC)) rdata_d = din;
        if (cnt_q == CNT_W'(PH_LAST)) begin
          cnt_d    = '0;
          state_d  = ST_RESP;
          tx_start = 1'b1;
          tx_byte  = rd_q ? rdata_q : RSP_OK;
`ifdef UART_DBG_AUTOINC_EN
          addr_d   = addr_q + 16'd1;
`else
          addr_d   = addr_q;
`endif
        end
      end
      ST_RESP: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      dout_q     <= '0;
      rd_q       <= 1'b1;
      rdata_q    <= '0;
      cnt_q      <= '0;
      frame_q    <= 1'b0;
      ovr_q      <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      ovr_q      <= ovr_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Phase 0 of BUS_CYC is address setup, phases 1..BUS_CYC strobe vma, last phase holds addr/rw.
  assign bus_req   = (state_q == ST_BUS_REQ) ||
                     (state_q == ST_BUS_CYC && cnt_q != CNT_W'(PH_LAST));
  assign vma       = (state_q == ST_BUS_CYC) && (cnt_q != '0) && (cnt_q != CNT_W'(PH_LAST));
  assign rw        = (state_q == ST_BUS_CYC) ? rd_q : 1'b1;
  assign addr      = addr_q;
  assign dout      = dout_q;
  assign txd       = tx_shift_q[0];
  assign err_frame = frame_q;
  assign err_ovr   = ovr_q;

endmodule

// File: tb/tb_uart_dbg_master.sv
// Directed bench for uart_dbg_master with a shortened bit period and timeout.
module tb_uart_dbg_master;

  localparam int OSC  = 160000;
  localparam int BAUD = 10000;
  localparam int BIT  = OSC / BAUD;  // 16 clk_in cycles per bit
  localparam int NCYC = 12;
  localparam int TOUT = 400;

  logic        clk_in = 1'b0;
  logic        b_reset;
  logic        rxd = 1'b1;
  logic        txd, bus_req, bus_ack, rw, vma, err_frame, err_ovr;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [7:0]  din = 8'h00;
  logic        ack_en = 1'b1;

  assign bus_ack = bus_req & ack_en;
  always #5 clk_in = ~clk_in;

  uart_dbg_master #(.OSC_CLOCK(OSC), .UART_BAUD(BAUD), .BUS_CYC(NCYC), .TIMEOUT(TOUT)) dut (
    .clk_in(clk_in), .b_reset(b_reset), .rxd(rxd), .txd(txd), .bus_req(bus_req),
    .bus_ack(bus_ack), .addr(addr), .dout(dout), .din(din), .rw(rw), .vma(vma),
    .err_frame(err_frame), .err_ovr(err_ovr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    int          len;
  } pulse_t;

  pulse_t      pulses[$];
  logic [7:0]  resps[$];
  int          bus_err = 0;
  int          req_cycles = 0;

  // Bus observer: records each vma pulse and checks setup and hold around it.
  logic        prev_vma = 1'b0, prev_rw = 1'b1;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_dout = '0;
  pulse_t      cur;
  always @(negedge clk_in) begin
    if (b_reset === 1'b1) begin
      if (bus_req) req_cycles++;
      if (vma && !prev_vma) begin
        if (prev_addr !== addr || prev_rw !== rw || prev_dout !== dout) bus_err++;
        cur.addr = addr; cur.rw = rw; cur.dout = dout; cur.len = 1;
      end else if (vma) begin
        cur.len++;
        if (addr !== cur.addr || rw !== cur.rw || dout !== cur.dout) bus_err++;
      end else if (prev_vma) begin
        pulses.push_back(cur);
        if (addr !== cur.addr || rw !== cur.rw || bus_req !== 1'b0) bus_err++;
      end
    end
    prev_vma = vma; prev_rw = rw; prev_addr = addr; prev_dout = dout;
  end

  // Response decoder on txd.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge txd);
      repeat (BIT / 2) @(negedge clk_in);
      if (txd == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk_in);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk_in);
        resps.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk_in);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk_in);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk_in);
    rxd = 1'b1;
    if (!stop_bit) repeat (BIT) @(negedge clk_in);
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while (resps.size() < n && k < 40 * BIT) begin
      @(negedge clk_in);
      k++;
    end
    repeat (2 * BIT) @(negedge clk_in);
  endtask

  task automatic clear();
    pulses.delete();
    resps.delete();
    req_cycles = 0;
  endtask

  function automatic logic [31:0] resp_at(input int i);
    return (resps.size() > i) ? {24'h0, resps[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic pulse_t pulse_at(input int i);
    pulse_t p;
    p = '{addr: 16'hDEAD, rw: 1'bx, dout: 8'hxx, len: -1};
    if (pulses.size() > i) p = pulses[i];
    return p;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] cmd;     // bytes sent MSB first
    int          ncmd;
    logic [7:0]  din;
    int          npulse;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    logic [7:0]  resp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [31:0] cmd, input int ncmd,
                              input logic [7:0] d, input int np, input logic [15:0] a,
                              input logic r, input logic [7:0] dq, input logic [7:0] rsp);
    vec_t v;
    v.name = name; v.cmd = cmd; v.ncmd = ncmd; v.din = d; v.npulse = np;
    v.addr = a; v.rw = r; v.dout = dq; v.resp = rsp;
    return v;
  endfunction

  initial begin
    pulse_t p;
    vecs.push_back(mk("write_e600", 32'h57E600A5, 4, 8'h00, 1, 16'hE600, 1'b0, 8'hA5, 8'h4B));
    vecs.push_back(mk("read_0010",  32'h52001000, 3, 8'h3C, 1, 16'h0010, 1'b1, 8'h00, 8'h3C));
    vecs.push_back(mk("unknown_41", 32'h41000000, 1, 8'h00, 0, 16'h0000, 1'b1, 8'h00, 8'h3F));
    vecs.push_back(mk("read_ffff",  32'h52FFFF00, 3, 8'h81, 1, 16'hFFFF, 1'b1, 8'h00, 8'h81));
    vecs.push_back(mk("write_1234", 32'h57123400, 4, 8'hFF, 1, 16'h1234, 1'b0, 8'h00, 8'h4B));
    vecs.push_back(mk("read_zero",  32'h52123400, 3, 8'h00, 1, 16'h1234, 1'b1, 8'h00, 8'h00));
    vecs.push_back(mk("unknown_00", 32'h00000000, 1, 8'h00, 0, 16'h0000, 1'b1, 8'h00, 8'h3F));
`ifndef UART_DBG_AUTOINC_EN
    vecs.push_back(mk("w_unknown",  32'h77000000, 1, 8'h00, 0, 16'h0000, 1'b1, 8'h00, 8'h3F));
    vecs.push_back(mk("r_unknown",  32'h72000000, 1, 8'h00, 0, 16'h0000, 1'b1, 8'h00, 8'h3F));
`endif

    b_reset = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_txd", txd, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_vma", vma, 0);
    check("rst_rw", rw, 1);
    check("rst_addr", addr, 0);
    check("rst_dout", dout, 0);
    check("rst_flags", {err_frame, err_ovr}, 0);
    b_reset = 1'b1;
    repeat (5) @(negedge clk_in);

    foreach (vecs[n]) begin
      clear();
      din = vecs[n].din;
      for (int k = 0; k < vecs[n].ncmd; k++) begin
        logic [31:0] c;
        c = vecs[n].cmd << (8 * k);
        send_byte(c[31:24]);
      end
      wait_resp(1);
      p = pulse_at(0);
      check({vecs[n].name, "_npulse"}, pulses.size(), vecs[n].npulse);
      check({vecs[n].name, "_req"}, (req_cycles > 0), (vecs[n].npulse > 0));
      if (vecs[n].npulse > 0) begin
        check({vecs[n].name, "_addr"}, p.addr, vecs[n].addr);
        check({vecs[n].name, "_rw"}, p.rw, vecs[n].rw);
        check({vecs[n].name, "_len"}, p.len, NCYC);
        if (!vecs[n].rw) check({vecs[n].name, "_dout"}, p.dout, vecs[n].dout);
      end
      check({vecs[n].name, "_nresp"}, resps.size(), 1);
      check({vecs[n].name, "_resp"}, resp_at(0), vecs[n].resp);
    end
    check("flags_after_table", {err_frame, err_ovr}, 0);

    // Abandoned command, then a slow but in-time command.
    clear();
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (TOUT + 4 * BIT) @(negedge clk_in);
    check("timeout_npulse", pulses.size(), 0);
    check("timeout_nresp", resps.size(), 0);
    din = 8'h5E;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    wait_resp(1);
    check("after_timeout_addr", pulse_at(0).addr, 16'h0010);
    check("after_timeout_resp", resp_at(0), 8'h5E);
    clear();
    din = 8'hC3;
    send_byte(8'h52);
    repeat (TOUT - 200) @(negedge clk_in);
    send_byte(8'h01);
    repeat (TOUT - 200) @(negedge clk_in);
    send_byte(8'h02);
    wait_resp(1);
    check("slow_cmd_addr", pulse_at(0).addr, 16'h0102);
    check("slow_cmd_resp", resp_at(0), 8'hC3);

    // Framing error: the 'R' must be ignored, so the next 'A' is an unknown command.
    clear();
    send_byte(8'h52, 1'b0);
    check("frame_err_set", err_frame, 1);
    send_byte(8'h41);
    wait_resp(1);
    check("frame_byte_ignored", resp_at(0), 8'h3F);
    check("frame_no_pulse", pulses.size(), 0);
    check("ovr_still_clear", err_ovr, 0);

    // Byte arriving during the response is dropped.
    clear();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'h5A);
    send_byte(8'h41);
    wait_resp(1);
    repeat (20 * BIT) @(negedge clk_in);
    check("ovr_flag", err_ovr, 1);
    check("ovr_nresp", resps.size(), 1);
    check("ovr_resp", resp_at(0), 8'h4B);
    check("ovr_addr", pulse_at(0).addr, 16'h0020);
    check("ovr_dout", pulse_at(0).dout, 8'h5A);

    // Grant withheld: bus_req stays up with no strobe until bus_ack.
    clear();
    ack_en = 1'b0;
    din = 8'h77;
    send_byte(8'h52); send_byte(8'hAB); send_byte(8'hCD);
    repeat (40 * BIT) @(negedge clk_in);
    check("stall_req", bus_req, 1);
    check("stall_vma", vma, 0);
    check("stall_npulse", pulses.size(), 0);
    ack_en = 1'b1;
    wait_resp(1);
    check("stall_addr", pulse_at(0).addr, 16'hABCD);
    check("stall_resp", resp_at(0), 8'h77);

`ifdef UART_DBG_AUTOINC_EN
    clear();
    send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h11);
    wait_resp(1);
    send_byte(8'h77); send_byte(8'h22);
    wait_resp(2);
    din = 8'h99;
    send_byte(8'h72);
    wait_resp(3);
    check("inc_npulse", pulses.size(), 3);
    check("inc_addr0", pulse_at(0).addr, 16'hFFFF);
    check("inc_dout0", pulse_at(0).dout, 8'h11);
    check("inc_addr1", pulse_at(1).addr, 16'h0000);
    check("inc_dout1", pulse_at(1).dout, 8'h22);
    check("inc_addr2", pulse_at(2).addr, 16'h0001);
    check("inc_resps", {resp_at(0)[7:0], resp_at(1)[7:0], resp_at(2)[7:0]}, 24'h4B4B99);
`endif

    // Reset while holding the bus: everything drops, no response follows.
    clear();
    ack_en = 1'b0;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    repeat (4) @(negedge clk_in);
    b_reset = 1'b0;
    #1;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_flags", {err_frame, err_ovr}, 0);
    check("midrst_addr", addr, 0);
    check("midrst_txd", txd, 1);
    repeat (3) @(negedge clk_in);
    b_reset = 1'b1;
    ack_en = 1'b1;
    repeat (20 * BIT) @(negedge clk_in);
    check("midrst_nresp", resps.size(), 0);
    check("midrst_npulse", pulses.size(), 0);

    check("bus_timing_errors", bus_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
